// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control path: ALUctl codes, ALUOp/funct codes, issue-stage states.
package alu_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } stage_state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Pure combinational ALUOp/funct -> ALUctl translation; also serves as the reference model in the ALU bench.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctl,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctl = CTL_AND;
        o_illegal = 1'b0;
        case (i_alu_op)
            OP_MEM:    o_alu_ctl = CTL_ADD;
            OP_BRANCH: o_alu_ctl = CTL_SUB;
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_alu_ctl = CTL_ADD;
                    FN_SUB:  o_alu_ctl = CTL_SUB;
                    FN_AND:  o_alu_ctl = CTL_AND;
                    FN_OR:   o_alu_ctl = CTL_OR;
                    FN_SLT:  o_alu_ctl = CTL_SLT;
                    FN_NOR:  o_alu_ctl = CTL_NOR;
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_stage.sv
// Registered issue stage feeding the ALU: decode, operand select, two-entry skid buffer, illegal-op counter.
//   state    | meaning
//   ST_EMPTY | no entry held, outputs invalid
//   ST_ONE   | main register holds the presented entry
//   ST_FULL  | main presented, skid holds the next entry; upstream stalled
module alu_control_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             aluSrc,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic [WIDTH-1:0] immExt,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       ALUctl,
    output logic             illegal,
    output logic [CNT_W-1:0] illegalCount
);

    stage_state_e     r_state;
    stage_state_e     w_state_nxt;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_consume;
    logic             w_load_main_new;
    logic             w_load_skid;
    logic             w_main_from_skid;

    logic [3:0]       w_ctl;
    logic             w_ill;
    logic [WIDTH-1:0] w_b;

    logic [WIDTH-1:0] r_main_a;
    logic [WIDTH-1:0] r_main_b;
    logic [3:0]       r_main_ctl;
    logic             r_main_ill;
    logic [WIDTH-1:0] r_skid_a;
    logic [WIDTH-1:0] r_skid_b;
    logic [3:0]       r_skid_ctl;
    logic             r_skid_ill;
    logic [CNT_W-1:0] r_ill_cnt;

    alu_ctl_decode u_decode (
        .i_alu_op  (ALUOp),
        .i_funct   (funct),
        .o_alu_ctl (w_ctl),
        .o_illegal (w_ill)
    );

    assign w_b       = aluSrc ? immExt : rtData;
    assign outValid  = (r_state != ST_EMPTY);
    assign w_accept  = inValid & r_in_ready;
    assign w_consume = outValid & outReady;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_new  = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt     = ST_ONE;
                    w_load_main_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_consume) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (!w_accept && w_consume) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && w_consume) begin
                    w_load_main_new = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_consume) begin
                    w_state_nxt      = ST_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // inReady is a flop loaded from the next state so it never depends on inputs combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_a   <= '0;
            r_main_b   <= '0;
            r_main_ctl <= 4'b0000;
            r_main_ill <= 1'b0;
            r_skid_a   <= '0;
            r_skid_b   <= '0;
            r_skid_ctl <= 4'b0000;
            r_skid_ill <= 1'b0;
        end else begin
            if (w_load_main_new) begin
                r_main_a   <= rsData;
                r_main_b   <= w_b;
                r_main_ctl <= w_ctl;
                r_main_ill <= w_ill;
            end else if (w_main_from_skid) begin
                r_main_a   <= r_skid_a;
                r_main_b   <= r_skid_b;
                r_main_ctl <= r_skid_ctl;
                r_main_ill <= r_skid_ill;
            end
            if (w_load_skid) begin
                r_skid_a   <= rsData;
                r_skid_b   <= w_b;
                r_skid_ctl <= w_ctl;
                r_skid_ill <= w_ill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ill_cnt <= '0;
        end else if (w_accept && w_ill && (r_ill_cnt != {CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign inReady      = r_in_ready;
    assign a            = r_main_a;
    assign b            = r_main_b;
    assign ALUctl       = r_main_ctl;
    assign illegal      = r_main_ill;
    assign illegalCount = r_ill_cnt;

endmodule

// File: doc/alu_control_stage.md
# alu_control_stage

Registered issue stage directly upstream of the ALU-with-control block. Accepts decoded-instruction fields (ALUOp, funct, register operands, sign-extended immediate) over a valid/ready handshake. Translates them into the 4-bit ALUctl code, selects the second operand, and presents the triple {a, b, ALUctl} to the ALU from registers. A two-entry skid buffer keeps full throughput while keeping `inReady` registered. A saturating counter records illegal encodings.

## Interface
- `WIDTH`, 32: operand width; must match the ALU's `a`/`b` width.
- `CNT_W`, 16: illegal-op counter width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `inValid`  in  1  upstream has a request.
- `inReady`  out  1  stage can accept; registered.
- `ALUOp`  in  2  00 = mem add, 01 = branch sub, 10 = R-type by funct, 11 = reserved.
- `funct`  in  6  R-type function field.
- `aluSrc`  in  1  0 = b from `rtData`, 1 = b from `immExt`.
- `rsData`  in  WIDTH  first operand.
- `rtData`  in  WIDTH  register second operand.
- `immExt`  in  WIDTH  sign-extended immediate.
- `outValid`  out  1  {a, b, ALUctl, illegal} valid.
- `outReady`  in  1  downstream consumes.
- `a`, `b`  out  WIDTH  operands to the ALU.
- `ALUctl`  out  4  ALU control code.
- `illegal`  out  1  entry carried an unsupported encoding.
- `illegalCount`  out  CNT_W  saturating count of accepted illegal requests.

## Operation
- Decode:
  - ALUOp 00 → 0010 (add); ALUOp 01 → 0110 (sub).
  - ALUOp 10 with funct:
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 101010 → 0111 (slt)
    - 100111 → 1100 (nor)
  - Any other funct, or ALUOp 11 → ALUctl 0000, `illegal` = 1.
- Operands: `a` = `rsData`; `b` = `aluSrc` ? `immExt` : `rtData`. Operands pass through unmodified, with no width change.
- Illegal entries still propagate downstream with `illegal` = 1; they are never dropped.
- Storage is a main output register plus a skid register, each holding {a, b, ALUctl, illegal}.
- States: EMPTY (main empty), ONE (main full), FULL (main and skid full).
  - EMPTY: accept → ONE.
  - ONE:
    - accept and no consume → FULL.
    - consume and no accept → EMPTY.
    - both → ONE; the new entry loads main.
  - FULL: consume → ONE; skid moves to main.
- `inReady` = 1 in EMPTY and ONE, 0 in FULL. It is updated from the next state.
- `outValid` = 1 in ONE and FULL.
- Accept = `inValid` & `inReady`. Consume = `outValid` & `outReady`.
- Output payload is stable while `outValid` & !`outReady`.
- `illegalCount` increments on accept of an illegal request and saturates at all-ones.

## Timing
- Latency: an entry accepted in cycle N is presented on outputs in cycle N+1. No combinational path exists from any input to any output.
- Throughput: one request per cycle while `outReady` = 1.
- When `outReady` drops, at most one further request is absorbed into skid. `inReady` is 0 from the following cycle.
- FULL with simultaneous consume: `inReady` is 1 next cycle. Ordering is strictly FIFO.
- Reset values: `outValid` 0, `inReady` 1, `a`/`b` 0, `ALUctl` 0000, `illegal` 0, `illegalCount` 0, state EMPTY.
- Reset mid-transfer discards both entries; the next cycle is EMPTY.
- `inValid` without `inReady` has no effect, and the request is not counted.

## Structure
- Shared package `alu_pkg`:
  - ALUctl constants: AND, OR, ADD, SUB, SLT, NOR.
  - ALUOp codes.
  - funct codes.
  - Stage state enum.
- Combinational sub-module `alu_ctl_decode` (ALUOp, funct → ALUctl, illegal). It is reused by the ALU bench as the reference model.
- Top level holds the skid FSM, the payload registers and the counter.

## Test plan
- Reset, then `inValid` = 1, ALUOp 10, funct 100010, rs = 5, rt = 3, `outReady` = 1 → next cycle `outValid` = 1, a = 5, b = 3, ALUctl = 0110, illegal = 0.
- Back-to-back stream of add/and/or/slt/nor with `outReady` = 1 → ALUctl sequence 0010, 0000, 0001, 0111, 1100 on consecutive cycles with no bubbles.
- `outReady` held 0 while three requests offered → first two captured, `inReady` = 0 from the third cycle, outputs stable. Release `outReady` → entries emerge in order, the third is accepted after `inReady` returns to 1.
- ALUOp 00, `aluSrc` = 1, immExt = 0xFFFFFFFC → b = 0xFFFFFFFC, ALUctl = 0010.
- funct 000000 with ALUOp 10, then ALUOp 11 → both emerge with `illegal` = 1, ALUctl = 0000. `illegalCount` = 2. With CNT_W = 2, five illegal requests leave the count at 3.
- Assert `reset` while FULL → next cycle `outValid` = 0, `inReady` = 1, `illegalCount` = 0.
